// File: rtl/cursor_cmd_gen.sv
// Cursor command generator: synchronizes, debounces, arbitrates and
// auto-repeats four buttons into a row/col/add_n/fire command bus.
module cursor_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic row_en,
  output logic col_en,
  output logic add_n,
  output logic fire
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 2) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 2);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT
  } state_t;

  // Button index: 0=up 1=down 2=left 3=right (also priority order)
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [DW-1:0] r_dcnt [4];

  state_t        r_state;
  state_t        w_nxt;
  logic [1:0]    r_dir;
  logic [1:0]    w_dir;
  logic [1:0]    w_pick;
  logic          r_first;
  logic [RW-1:0] r_rcnt;
  logic          w_hit;
  logic          w_go;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizer followed by a mismatch-count debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_dcnt[i] <= '0;
          r_deb[i]  <= r_sync2[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Fixed-priority pick among debounced-pressed buttons
  always_comb begin
    w_pick = 2'd3;
    if (r_deb[0])      w_pick = 2'd0;
    else if (r_deb[1]) w_pick = 2'd1;
    else if (r_deb[2]) w_pick = 2'd2;
  end

  assign w_hit = (r_rcnt == (r_first ? DLY_LAST : PER_LAST));

  // Next-state logic; dir is only re-chosen when leaving IDLE
  always_comb begin
    w_nxt = r_state;
    w_dir = r_dir;
    unique case (r_state)
      S_IDLE: begin
        if (|r_deb) begin
          w_nxt = S_FIRE;
          w_dir = w_pick;
        end
      end
      S_FIRE: w_nxt = S_WAIT;
      S_WAIT: begin
        if (!r_deb[r_dir]) w_nxt = S_IDLE;
        else if (w_hit)    w_nxt = S_FIRE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_go = (w_nxt == S_FIRE);

  // State, repeat counter and registered command outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 2'd0;
      r_first <= 1'b0;
      r_rcnt  <= '0;
      fire    <= 1'b0;
      row_en  <= 1'b0;
      col_en  <= 1'b0;
      add_n   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_dir   <= w_dir;
      if (r_state != S_WAIT) r_rcnt <= '0;
      else if (!w_hit)       r_rcnt <= r_rcnt + 1'b1;
      if (r_state == S_IDLE && w_go)      r_first <= 1'b1;
      else if (r_state == S_WAIT && w_go) r_first <= 1'b0;
      fire   <= w_go;
      row_en <= w_go & ~w_dir[1];
      col_en <= w_go & w_dir[1];
      add_n  <= w_go & ~w_dir[0];
    end
  end

endmodule

// File: doc/cursor_cmd_gen.md
# cursor_cmd_gen

Front-end command generator for the cursor position counters. Converts four raw push-buttons into the `row_en` / `col_en` / `add_n` / `fire` command bus that the row and column cursor counters consume. Synchronizes, debounces, arbitrates and auto-repeats the buttons. Guarantees that `fire` is a single-cycle strobe and is never high on two consecutive cycles.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable samples required to change a debounced level; must be ≥1.
- `REPEAT_DELAY`, default 50000000: cycles from the first `fire` rise to the first auto-repeat `fire` rise; must be ≥2.
- `REPEAT_PERIOD`, default 10000000: cycles between successive auto-repeat `fire` rises; must be ≥2.

Ports:
- `clk`, input, 1: single clock; all state on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, input, 1 each: raw asynchronous buttons, active-high.
- `row_en`, output, 1: command targets the row counter.
- `col_en`, output, 1: command targets the column counter.
- `add_n`, output, 1: 0 = increment, 1 = decrement.
- `fire`, output, 1: one-cycle command strobe.

## Operation
- Per-button input path:
  - 2-flop synchronizer.
  - Debouncer: counter cleared on any sample equal to the current debounced level. Debounced level flips at the `DEBOUNCE_CYCLES`-th consecutive edge where the synced level differs from it.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no change.
- Direction map:
  - up: `row_en=1`, `add_n=1`.
  - down: `row_en=1`, `add_n=0`.
  - left: `col_en=1`, `add_n=1`.
  - right: `col_en=1`, `add_n=0`.
- Priority when more than one button is debounced-pressed in IDLE: up > down > left > right. The winner is latched as `dir`.
- FSM states:
  - IDLE: waits for any debounced-pressed button; latches `dir`; goes to FIRE.
  - FIRE: exactly one cycle. Drives `fire=1` and the `dir` outputs. Next state is WAIT.
  - WAIT: counts toward the repeat threshold, which is `REPEAT_DELAY` before the first repeat and `REPEAT_PERIOD` afterwards.
    - Latched button debounced-released: go to IDLE.
    - Threshold reached: go to FIRE.
- `row_en`, `col_en` and `add_n` are nonzero only in FIRE; outside FIRE all three are 0. Each output is registered.
- Buttons other than the latched one are ignored while in FIRE or WAIT.
- If the latched button is released while another button is still held, the FSM passes through IDLE and then issues FIRE for the held button (minimum one-cycle gap).
- If the release is detected during the FIRE cycle, the strobe completes, then the FSM goes to WAIT, then IDLE on the next edge.
- Counter widths use `$clog2` of the respective parameter. Counters never wrap; each saturates or clears on a state change.

## Timing
- Reset: all outputs 0, FSM in IDLE, synchronizers and debounced levels 0 (unpressed), all counters 0. Reset mid-repeat aborts immediately.
- A button held through reset is treated as a new press after reset deasserts.
- Press latency: let edge 0 be the first edge that samples the raw button high (or the first edge after `rst` falls). `fire` is high in the cycle following edge `DEBOUNCE_CYCLES+2`.
- Release latency: the debounced level falls `DEBOUNCE_CYCLES+1` edges after the first low sample. The FSM reacts at the next edge.
- Repeat spacing, measured `fire` rise to rise: first repeat = `REPEAT_DELAY`, subsequent repeats = `REPEAT_PERIOD`.
- `fire` is high for exactly one cycle, and there is at least one low cycle between any two strobes.
- `row_en`, `col_en` and `add_n` are valid in the same cycle as `fire`. A consumer may use combinational `fire & (row_en | col_en)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`; cycle numbers are relative to edge 0.
- `btn_right` held 10 cycles, then released -> exactly one `fire`, at cycle 6, with `col_en=1`, `row_en=0`, `add_n=0`. All outputs 0 otherwise.
- `btn_up` high for 3 cycles, then low -> no `fire`; all outputs stay 0.
- `btn_down` held 50 cycles -> `fire` at cycles 6, 26, 34, 42 and 50 (5 strobes), each with `row_en=1`, `add_n=0`. No strobe at 58. `fire` is never high on 2 consecutive cycles.
- `btn_up` and `btn_left` rise on the same cycle and are held 15 cycles -> single `fire` at cycle 6 with `row_en=1`, `add_n=1`, `col_en=0`.
- `btn_left` held; `rst` pulsed for 1 cycle at cycle 30 (during WAIT) -> outputs 0 from cycle 31. With `btn_left` still held, next `fire` comes 7 cycles after `rst` falls, with `col_en=1`, `add_n=1`.
- `btn_left` held, `btn_right` pressed at cycle 10, `btn_left` released at cycle 12 -> left `fire` at 6. Right `fire` about 7 cycles after the left release (after the left debounce plus one IDLE cycle), with `col_en=1`, `add_n=0`.
